// File: rtl/calc_key_ctrl.sv
// Keypad calculator controller: decimal operand entry, + - * / with chaining, overflow and divide-by-zero error.
// add/sub/mul: done one edge after CALC entry; div: DIV_CYCLES-step restoring divider; clear aborts anything.
module calc_key_ctrl #(
    parameter int MAX_DIGITS = 4,
    parameter int DIV_CYCLES = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic signed [27:0] disp_value,
    output logic               err,
    output logic               busy,
    output logic               done
);
    localparam int CW  = $clog2(MAX_DIGITS + 1);
    localparam int DCW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0]  MAXD     = CW'(MAX_DIGITS);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_CYCLES - 1);
    localparam logic [41:0]    LIMIT    = 42'd99999999;
    localparam logic [1:0]     OP_DIV   = 2'd3;

    typedef enum logic [2:0] {ENTER_A, OP, ENTER_B, CALC, DIV, RESULT, ERR} state_t;

    state_t             state_q, state_d;
    logic signed [27:0] a_q, a_d, res_q, res_d, disp_q, disp_d;
    logic [13:0]        b_q, b_d, rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [27:0]        quo_q, quo_d;
    logic [DCW-1:0]     dcnt_q, dcnt_d;
    logic               err_q, err_d, busy_q, busy_d, done_q, done_d;

    logic               is_digit, is_op, is_eq, is_clr;
    logic [1:0]         key_op;
    logic signed [27:0] a_acc;
    logic [13:0]        b_acc;
    logic signed [41:0] a_ext, b_ext, arith;
    logic [41:0]        arith_mag;
    logic               ovf;
    logic [27:0]        a_mag, quo_sh, div_res;
    logic [14:0]        rem_sh;
    logic               take;

    always_comb begin
        is_digit = key_valid && (key_code <= 4'd9);
        is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
        is_eq    = key_valid && (key_code == 4'd14);
        is_clr   = key_valid && (key_code == 4'd15);
        key_op   = 2'(key_code - 4'd10);
        a_acc    = 28'(a_q * 28'sd10) + 28'(key_code);
        b_acc    = 14'(b_q * 14'd10) + 14'(key_code);

        // Datapath is wide enough that the largest chained product cannot wrap before the range check.
        a_ext = {{14{a_q[27]}}, a_q};
        b_ext = {28'd0, b_q};
        case (op_q)
            2'd0:    arith = a_ext + b_ext;
            2'd1:    arith = a_ext - b_ext;
            2'd2:    arith = a_ext * b_ext;
            default: arith = '0;
        endcase
        arith_mag = arith[41] ? -arith : arith;
        ovf       = arith_mag > LIMIT;

        // One restoring step on magnitudes; the sign of A is reapplied to the quotient at the end.
        a_mag   = a_q[27] ? -a_q : a_q;
        rem_sh  = {rem_q, quo_q[27]};
        take    = rem_sh >= {1'b0, b_q};
        quo_sh  = {quo_q[26:0], take};
        div_res = a_q[27] ? -quo_sh : quo_sh;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dcnt_d  = dcnt_q;
        done_d  = 1'b0;

        if (is_clr) begin
            state_d = ENTER_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = 2'd0;
            cnt_d   = '0;
            res_d   = '0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (is_digit && (cnt_q < MAXD)) begin
                        a_d = a_acc;
                        if (a_acc != '0) cnt_d = cnt_q + CW'(1);
                    end else if (is_op) begin
                        op_d    = key_op;
                        b_d     = '0;
                        state_d = OP;
                    end
                end
                OP: begin
                    if (is_op) begin
                        op_d = key_op;
                    end else if (is_digit) begin
                        b_d     = 14'(key_code);
                        cnt_d   = (key_code != 4'd0) ? CW'(1) : '0;
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit && (cnt_q < MAXD)) begin
                        b_d = b_acc;
                        if (b_acc != '0) cnt_d = cnt_q + CW'(1);
                    end else if (is_eq) begin
                        state_d = CALC;
                    end
                end
                CALC: begin
                    if (op_q == OP_DIV) begin
                        if (b_q == '0) begin
                            state_d = ERR;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_mag;
                            dcnt_d  = '0;
                            state_d = DIV;
                        end
                    end else if (ovf) begin
                        state_d = ERR;
                    end else begin
                        res_d   = arith[27:0];
                        done_d  = 1'b1;
                        state_d = RESULT;
                    end
                end
                DIV: begin
                    rem_d  = take ? 14'(rem_sh - {1'b0, b_q}) : rem_sh[13:0];
                    quo_d  = quo_sh;
                    dcnt_d = dcnt_q + DCW'(1);
                    if (dcnt_q == DIV_LAST) begin
                        res_d   = div_res;
                        done_d  = 1'b1;
                        state_d = RESULT;
                    end
                end
                RESULT: begin
                    if (is_digit) begin
                        a_d     = 28'(key_code);
                        b_d     = '0;
                        cnt_d   = (key_code != 4'd0) ? CW'(1) : '0;
                        state_d = ENTER_A;
                    end else if (is_op) begin
                        a_d     = res_q;
                        b_d     = '0;
                        op_d    = key_op;
                        state_d = OP;
                    end
                end
                ERR:     state_d = ERR;
                default: state_d = ENTER_A;
            endcase
        end

        // Outputs are derived from next-state values so they register in step with the state.
        busy_d = (state_d == CALC) || (state_d == DIV);
        err_d  = (state_d == ERR);
        case (state_d)
            ENTER_B: disp_d = {14'd0, b_d};
            RESULT:  disp_d = res_d;
            ERR:     disp_d = '0;
            default: disp_d = a_d;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'd0;
            cnt_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dcnt_q  <= '0;
            disp_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dcnt_q  <= dcnt_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign disp_value = disp_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_calc_key_ctrl.sv
// Directed bench for calc_key_ctrl: hand-computed results, latency, busy length, error and abort paths.
module tb_calc_key_ctrl;
    logic               clk;
    logic               rst;
    logic               key_valid;
    logic [3:0]         key_code;
    logic signed [27:0] disp_value;
    logic               err;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;
    int busy_cnt;
    int steps;
    bit seen;

    localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12, K_DIV = 4'd13,
                           K_EQ = 4'd14, K_CLR = 4'd15;

    calc_key_ctrl #(.MAX_DIGITS(4), .DIV_CYCLES(28)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .disp_value (disp_value),
        .err        (err),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge, after the key was taken on the edge between.
    task automatic key(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Counts busy cycles until done, bounded; timeout leaves found=0.
    task automatic wait_done(output int bcnt, output int nsteps, output bit found);
        bcnt   = 0;
        nsteps = 0;
        found  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            if (busy) bcnt++;
            nsteps++;
            @(negedge clk);
        end
    endtask

    task automatic watch_done(input int n, output bit found);
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (done) found = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        @(negedge clk);
        check("rst_disp", disp_value, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        idle(2);

        // 12 + 34 = 46, back-to-back keys
        key(4'd1); key(4'd2);
        check("entry_12", disp_value, 12);
        key(K_ADD);
        check("op_shows_a", disp_value, 12);
        key(4'd3); key(4'd4);
        check("entry_b_34", disp_value, 34);
        key(K_EQ);
        check("add_calc_busy", busy, 1);
        check("add_calc_nodone", done, 0);
        @(negedge clk);
        check("add_done", done, 1);
        check("add_busy_off", busy, 0);
        check("add_result", disp_value, 46);
        @(negedge clk);
        check("add_done_pulse", done, 0);
        key(4'd6);
        check("result_digit_restart", disp_value, 6);
        key(K_CLR);
        check("clr_disp", disp_value, 0);

        // 1 - 8 = -7, then chained / 2 = -3 through the divider
        key(4'd1); key(K_SUB); key(4'd8); key(K_EQ);
        idle(1);
        check("sub_done", done, 1);
        check("sub_result", disp_value, -7);
        key(K_DIV); key(4'd2); key(K_EQ);
        wait_done(busy_cnt, steps, seen);
        check("div_done_seen", seen, 1);
        check("div_busy_cycles", busy_cnt, 29);
        check("div_latency", steps, 29);
        check("div_result", disp_value, -3);
        key(K_CLR);

        // 9999 * 9999 fits; chained * 2 overflows
        for (int i = 0; i < 4; i++) key(4'd9);
        key(K_MUL);
        for (int i = 0; i < 4; i++) key(4'd9);
        key(K_EQ);
        idle(1);
        check("mul_done", done, 1);
        check("mul_result", disp_value, 99980001);
        key(K_MUL); key(4'd2); key(K_EQ);
        idle(1);
        check("ovf_err", err, 1);
        check("ovf_disp", disp_value, 0);
        watch_done(3, seen);
        check("ovf_no_done", seen, 0);
        key(K_CLR);
        check("ovf_clr_err", err, 0);
        check("ovf_clr_disp", disp_value, 0);

        // 7 / 0 -> error one edge after CALC entry, digits ignored in ERR
        key(4'd7); key(K_DIV); key(4'd0); key(K_EQ);
        check("dz_calc_noerr", err, 0);
        @(negedge clk);
        check("dz_err", err, 1);
        check("dz_done", done, 0);
        check("dz_disp", disp_value, 0);
        key(4'd5);
        check("dz_digit_ignored_err", err, 1);
        check("dz_digit_ignored_disp", disp_value, 0);
        key(K_CLR);
        check("dz_clr", err, 0);

        // Leading zeros, digit limit, last operator wins
        key(4'd0); key(4'd0); key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check("digit_limit", disp_value, 1234);
        key(K_ADD); key(K_ADD); key(K_SUB); key(4'd5);
        check("op_last_b", disp_value, 5);
        key(K_EQ);
        idle(1);
        check("op_last_done", done, 1);
        check("op_last_result", disp_value, 1229);
        key(K_CLR);

        // Clear 10 cycles into a division aborts it
        for (int i = 0; i < 4; i++) key(4'd9);
        key(K_DIV); key(4'd7); key(K_EQ);
        idle(10);
        check("abort_busy_before", busy, 1);
        key(K_CLR);
        check("abort_busy_off", busy, 0);
        check("abort_disp", disp_value, 0);
        watch_done(40, seen);
        check("abort_no_done", seen, 0);

        // Asynchronous reset mid-entry
        key(4'd4); key(4'd2);
        check("pre_rst_disp", disp_value, 42);
        #2 rst = 1'b1;
        #1;
        check("async_rst_disp", disp_value, 0);
        check("async_rst_err", err, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-division discards it
        key(4'd8); key(K_DIV); key(4'd2); key(K_EQ);
        idle(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        watch_done(40, seen);
        check("rst_div_no_done", seen, 0);
        check("rst_div_busy", busy, 0);
        key(4'd3);
        check("rst_div_enter_a", disp_value, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_key_ctrl.md
CALC_KEY_CTRL -- requirements
Module: calc_key_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, maximum decimal digits per entered operand.
REQ-002 SHALL have parameter DIV_CYCLES, default 28, iteration count of the sequential divider; equals result magnitude width.
REQ-003 SHALL have input clk, 1 bit, system clock; all state changes on the rising edge.
REQ-004 SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have input key_valid, 1 bit, one-cycle pulse from the debounce stage.
REQ-006 SHALL have input key_code, 4 bits, sampled only when key_valid=1: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear.
REQ-007 SHALL have output disp_value, 28 bits signed, value to be shown on the display.
REQ-008 SHALL have output err, 1 bit, error latched.
REQ-009 SHALL have output busy, 1 bit, computation in progress.
REQ-010 SHALL have output done, 1 bit, one-cycle pulse when a result is registered.

Function
REQ-011 SHALL implement states ENTER_A, OP, ENTER_B, CALC, DIV, RESULT, ERR.
REQ-012 SHALL hold operand A as signed 28-bit, operand B as unsigned 14-bit, the operator as 2 bits, and a digit counter.
REQ-013 SHALL, on a digit d in ENTER_A, set A=A*10+d only if the digit count < MAX_DIGITS; the count increments only when the new A is nonzero, so leading zeros do not count; extra digits are ignored.
REQ-014 SHALL, on an operator in ENTER_A, latch the operator, clear B, and go to OP; in OP, a new operator replaces the old one (last wins).
REQ-015 SHALL, on digit d in OP, set B=d, set the digit count to (d!=0), and go to ENTER_B; further digits follow the REQ-013 rule applied to B.
REQ-016 SHALL, on equals in ENTER_B, go to CALC; equals in ENTER_A, OP or RESULT and operators in ENTER_B are ignored.
REQ-017 SHALL, for add/sub/mul in CALC, register the result A op B on the next edge, pulse done, and go to RESULT (done high in the second cycle after the accepting edge).
REQ-018 SHALL, for div with B!=0, use DIV_CYCLES cycles in DIV (restoring, on magnitudes, quotient truncated toward zero, sign = sign of A); done pulses on the edge leaving DIV, i.e. DIV_CYCLES+1 edges after CALC entry.
REQ-019 SHALL, for div with B=0, go to ERR on the CALC edge, with no done pulse.
REQ-020 SHALL go to ERR with no done pulse if |result| > 99999999.
REQ-021 SHALL, in RESULT, on a digit d set A=d and go to ENTER_A; on an operator set A=result, latch the operator and go to OP (chaining).
REQ-022 SHALL drive disp_value as follows: A in ENTER_A/OP; B in ENTER_B; A during CALC/DIV; result in RESULT; 0 in ERR.
REQ-023 SHALL drive busy=1 only in CALC and DIV, and ignore every key except clear while busy.
REQ-024 SHALL treat clear in any state, including DIV, as: A=B=0, err=0, abort the divider, no done pulse, go to ENTER_A on the next edge.
REQ-025 SHALL hold err=1 in ERR; only clear exits ERR.
REQ-026 SHALL treat key_valid on consecutive cycles as independent keys.

Reset
REQ-027 SHALL, on rst=1, immediately force state ENTER_A, A=B=0, operator add, digit count 0, disp_value=0, err=0, busy=0, done=0, independent of clk.
REQ-028 SHALL, if rst is asserted mid-DIV, discard the computation without producing a done pulse after release.

Verification
REQ-029 SHALL pass: keys 1,2,+,3,4,= -> done high in the second cycle after the equals edge; disp_value=46; busy=1 for exactly one cycle.
REQ-030 SHALL pass: keys 1,-,8,= -> -7; then /,2,= -> busy for 29 cycles, done, disp_value=-3.
REQ-031 SHALL pass: keys 9,9,9,9,*,9,9,9,9,= -> 99980001; then *,2,= -> err=1, disp_value=0, no done; clear -> err=0, disp_value=0.
REQ-032 SHALL pass: keys 7,/,0,= -> err=1 one edge after CALC entry, no done; digit keys are ignored until clear.
REQ-033 SHALL pass: keys 0,0,1,2,3,4,5 -> disp_value=1234; keys +,+,-,5,= -> operator sub applies, disp_value=1229.
REQ-034 SHALL pass: clear issued 10 cycles into a division -> busy=0 next cycle, no done pulse ever; rst pulse mid-entry -> all outputs 0 asynchronously.
